// File: rtl/door_pkg.sv
// rtl/door_pkg.sv - shared state type, default timing constants and width helper for the door bank
package door_pkg;

    typedef enum logic [1:0] {
        DOOR_IDLE = 2'd0,
        DOOR_OPEN = 2'd1,
        DOOR_WARN = 2'd2
    } door_state_e;

    localparam int unsigned DEF_OPEN_TICKS = 20;
    localparam int unsigned DEF_WARN_TICKS = 4;
    localparam int unsigned DEF_BLINK_DIV  = 1;

    // Bits needed to hold the values 0..ticks.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/door_channel.sv
// rtl/door_channel.sv - one door: request edge detect, IDLE/OPEN/WARN timer, blink phase, done pulse
module door_channel
    import door_pkg::*;
#(
    parameter int unsigned OPEN_TICKS = DEF_OPEN_TICKS,
    parameter int unsigned WARN_TICKS = DEF_WARN_TICKS,
    parameter int unsigned BLINK_DIV  = DEF_BLINK_DIV,
    parameter bit          RETRIGGER  = 1'b1
) (
    input  logic clk_2Hz,
    input  logic reset,
    input  logic open_signal,
    input  logic obstruct,
    output logic door_led,
    output logic door_busy,
    output logic door_done,
    output logic busy_next
);
    localparam int unsigned CW = cnt_width(OPEN_TICKS);
    localparam int unsigned PW = cnt_width(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(OPEN_TICKS - 1);
    localparam logic [CW-1:0] CNT_WARN = CW'(OPEN_TICKS - WARN_TICKS);
    localparam logic [PW-1:0] PH_LAST  = PW'(BLINK_DIV - 1);

    door_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          led_q, led_d;
    logic          done_q, done_d;
    logic          open_q, arm_q;
    logic          req_edge;

    // arm_q stays low until the request has been seen low once, so a level held through reset is no edge.
    assign req_edge = open_signal & ~open_q & arm_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        led_d   = led_q;
        done_d  = 1'b0;
        unique case (state_q)
            DOOR_IDLE: begin
                led_d = 1'b0;
                if (req_edge) begin
                    state_d = DOOR_OPEN;
                    cnt_d   = '0;
                    phase_d = '0;
                    led_d   = 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (obstruct) begin
                    led_d = 1'b1;
                end else if (WARN_TICKS == 0 && cnt_q == CNT_LAST) begin
                    state_d = DOOR_IDLE;
                    cnt_d   = '0;
                    phase_d = '0;
                    led_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        led_d   = ~led_q;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                    if (cnt_d == CNT_WARN) begin
                        state_d = DOOR_WARN;
                        led_d   = 1'b1;
                    end
                end
            end
            DOOR_WARN: begin
                led_d = 1'b1;
                if (!obstruct) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DOOR_IDLE;
                        cnt_d   = '0;
                        phase_d = '0;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = DOOR_IDLE;
        endcase
        // A fresh request restarts the window ahead of both expiry and obstruction.
        if (RETRIGGER && req_edge && state_q != DOOR_IDLE) begin
            state_d = DOOR_OPEN;
            cnt_d   = '0;
            phase_d = '0;
            led_d   = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_2Hz or posedge reset) begin
        if (reset) begin
            state_q <= DOOR_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            open_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            done_q  <= done_d;
            open_q  <= open_signal;
            arm_q   <= arm_q | ~open_signal;
        end
    end

    assign door_led  = led_q;
    assign door_busy = (state_q != DOOR_IDLE);
    assign door_done = done_q;
    assign busy_next = (state_d != DOOR_IDLE);

endmodule

// File: rtl/door_bank_ctrl.sv
// rtl/door_bank_ctrl.sv - bank of independent door channels with a registered busy-door count
module door_bank_ctrl
    import door_pkg::*;
#(
    parameter int unsigned N_DOORS    = 4,
    parameter int unsigned OPEN_TICKS = DEF_OPEN_TICKS,
    parameter int unsigned WARN_TICKS = DEF_WARN_TICKS,
    parameter int unsigned BLINK_DIV  = DEF_BLINK_DIV,
    parameter bit          RETRIGGER  = 1'b1
) (
    input  logic                             clk_2Hz,
    input  logic                             reset,
    input  logic [N_DOORS-1:0]               open_signal,
    input  logic [N_DOORS-1:0]               obstruct,
    output logic [N_DOORS-1:0]               DoorLED,
    output logic [N_DOORS-1:0]               door_busy,
    output logic [N_DOORS-1:0]               door_done,
    output logic [$clog2(N_DOORS+1)-1:0]     busy_count
);
    localparam int unsigned BW = $clog2(N_DOORS + 1);

    logic [N_DOORS-1:0] busy_next;
    logic [BW-1:0]      count_d, count_q;

    if (N_DOORS < 1 || N_DOORS > 16 || OPEN_TICKS < 2 || WARN_TICKS >= OPEN_TICKS || BLINK_DIV < 1)
    begin : g_param_check
        $error("door_bank_ctrl: illegal parameter combination");
    end

    for (genvar i = 0; i < N_DOORS; i++) begin : g_door
        door_channel #(
            .OPEN_TICKS (OPEN_TICKS),
            .WARN_TICKS (WARN_TICKS),
            .BLINK_DIV  (BLINK_DIV),
            .RETRIGGER  (RETRIGGER)
        ) u_channel (
            .clk_2Hz     (clk_2Hz),
            .reset       (reset),
            .open_signal (open_signal[i]),
            .obstruct    (obstruct[i]),
            .door_led    (DoorLED[i]),
            .door_busy   (door_busy[i]),
            .door_done   (door_done[i]),
            .busy_next   (busy_next[i])
        );
    end

    // Counting next-state busy bits keeps the count aligned with door_busy.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < N_DOORS; i++) begin
            count_d = count_d + BW'(busy_next[i]);
        end
    end

    always_ff @(posedge clk_2Hz or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;

endmodule

// File: tb/tb_door_bank_ctrl.sv
// tb/tb_door_bank_ctrl.sv - directed table-driven bench for door_bank_ctrl
module tb_door_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] open_a, obs_a, led_a, busy_a, done_a;
    logic [3:0] open_n, obs_n, led_n, busy_n, done_n;
    logic [3:0] open_b, obs_b, led_b, busy_b, done_b;
    logic [2:0] cnt_a, cnt_n, cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    door_bank_ctrl #(.N_DOORS(4), .OPEN_TICKS(20), .WARN_TICKS(4), .BLINK_DIV(1), .RETRIGGER(1)) dut_a (
        .clk_2Hz(clk), .reset(rst), .open_signal(open_a), .obstruct(obs_a),
        .DoorLED(led_a), .door_busy(busy_a), .door_done(done_a), .busy_count(cnt_a));

    door_bank_ctrl #(.N_DOORS(4), .OPEN_TICKS(20), .WARN_TICKS(4), .BLINK_DIV(1), .RETRIGGER(0)) dut_n (
        .clk_2Hz(clk), .reset(rst), .open_signal(open_n), .obstruct(obs_n),
        .DoorLED(led_n), .door_busy(busy_n), .door_done(done_n), .busy_count(cnt_n));

    door_bank_ctrl #(.N_DOORS(4), .OPEN_TICKS(20), .WARN_TICKS(0), .BLINK_DIV(3), .RETRIGGER(1)) dut_b (
        .clk_2Hz(clk), .reset(rst), .open_signal(open_b), .obstruct(obs_b),
        .DoorLED(led_b), .door_busy(busy_b), .door_done(done_b), .busy_count(cnt_b));

    typedef struct {
        logic       sel_b;
        logic [3:0] open;
        logic [3:0] led;
        logic [3:0] busy;
        logic [3:0] done;
        logic [2:0] count;
    } vec_t;

    vec_t tab[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        open_a = 4'b0; obs_a = 4'b0;
        open_n = 4'b0; obs_n = 4'b0;
        open_b = 4'b0; obs_b = 4'b0;
    endtask

    // Request at step 0 (and at step retrig), obstruct on steps obs_lo..obs_hi; measure the busy window.
    task automatic run_window(input int inst, input int door, input int retrig, input int obs_lo,
                              input int obs_hi, output int busy_cycles, output int done_at);
        logic [3:0] m;
        logic [3:0] o;
        logic [3:0] b;
        m = 4'b0001 << door;
        busy_cycles = 0;
        done_at = -1;
        for (int s = 0; s < 80 && done_at < 0; s++) begin
            o = (s == 0 || s == retrig) ? m : 4'b0;
            b = (s >= obs_lo && s <= obs_hi) ? m : 4'b0;
            if (inst == 0) begin open_a = o; obs_a = b; end
            else           begin open_n = o; obs_n = b; end
            tick();
            if (inst == 0) begin
                if (busy_a[door]) busy_cycles++;
                if (done_a[door]) done_at = s;
                if (b != 4'b0) check("obstruct_led", led_a[door], 1);
            end else begin
                if (busy_n[door]) busy_cycles++;
                if (done_n[door]) done_at = s;
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        vec_t v;
        int   bc, da;

        for (int i = 0; i < 22; i++) begin
            v.sel_b = 1'b0;
            v.open  = (i == 0) ? 4'b0001 : 4'b0000;
            v.led   = {3'b0, (i < 16) ? ~i[0] : (i < 20)};
            v.busy  = {3'b0, (i < 20)};
            v.done  = {3'b0, (i == 20)};
            v.count = (i < 20) ? 3'd1 : 3'd0;
            tab.push_back(v);
        end
        for (int i = 0; i < 22; i++) begin
            v.sel_b = 1'b1;
            v.open  = (i == 0) ? 4'b0001 : 4'b0000;
            v.led   = {3'b0, (i < 20) && ((i / 3) % 2 == 0)};
            v.busy  = {3'b0, (i < 20)};
            v.done  = {3'b0, (i == 20)};
            v.count = (i < 20) ? 3'd1 : 3'd0;
            tab.push_back(v);
        end

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_led",   {led_a, led_n, led_b}, 0);
        check("reset_busy",  {busy_a, busy_n, busy_b}, 0);
        check("reset_done",  {done_a, done_n, done_b}, 0);
        check("reset_count", {cnt_a, cnt_n, cnt_b}, 0);
        #2 rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < tab.size(); i++) begin
            clear_inputs();
            if (tab[i].sel_b) open_b = tab[i].open;
            else              open_a = tab[i].open;
            tick();
            if (tab[i].sel_b) begin
                check($sformatf("tabB[%0d]_led", i),   led_b,  tab[i].led);
                check($sformatf("tabB[%0d]_busy", i),  busy_b, tab[i].busy);
                check($sformatf("tabB[%0d]_done", i),  done_b, tab[i].done);
                check($sformatf("tabB[%0d]_count", i), cnt_b,  tab[i].count);
            end else begin
                check($sformatf("tabA[%0d]_led", i),   led_a,  tab[i].led);
                check($sformatf("tabA[%0d]_busy", i),  busy_a, tab[i].busy);
                check($sformatf("tabA[%0d]_done", i),  done_a, tab[i].done);
                check($sformatf("tabA[%0d]_count", i), cnt_a,  tab[i].count);
            end
        end
        clear_inputs();
        tick();

        run_window(0, 1, -1, 9, 13, bc, da);
        check("obstruct_busy_cycles", bc, 25);
        check("obstruct_done_step",   da, 25);

        run_window(0, 2, 18, 99, 0, bc, da);
        check("retrig_warn_busy_cycles", bc, 38);
        check("retrig_warn_done_step",   da, 38);

        run_window(1, 2, 18, 99, 0, bc, da);
        check("noretrig_busy_cycles", bc, 20);
        check("noretrig_done_step",   da, 20);

        run_window(0, 3, 20, 99, 0, bc, da);
        check("retrig_expiry_busy_cycles", bc, 40);
        check("retrig_expiry_done_step",   da, 40);

        run_window(0, 0, 10, 10, 12, bc, da);
        check("retrig_obstruct_busy_cycles", bc, 32);
        check("retrig_obstruct_done_step",   da, 32);

        open_a = 4'hF;
        tick();
        check("all4_count_first", cnt_a, 4);
        check("all4_busy_first",  busy_a, 4'hF);
        check("all4_led_first",   led_a, 4'hF);
        open_a = 4'h0;
        repeat (19) tick();
        check("all4_count_last", cnt_a, 4);
        tick();
        check("all4_done",  done_a, 4'hF);
        check("all4_busy_end", busy_a, 4'h0);
        check("all4_count_end", cnt_a, 0);
        tick();
        check("all4_done_cleared", done_a, 4'h0);

        open_a = 4'b0001;
        repeat (8) tick();
        check("rst_mid_busy_before", busy_a[0], 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_led",   led_a, 0);
        check("rst_mid_busy",  busy_a, 0);
        check("rst_mid_done",  done_a, 0);
        check("rst_mid_count", cnt_a, 0);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_held_level[%0d]", i), busy_a[0], 0);
        end
        open_a = 4'b0000;
        tick();
        check("rst_low_idle", busy_a[0], 0);
        open_a = 4'b0001;
        tick();
        check("rst_rearm_busy", busy_a[0], 1);
        check("rst_rearm_led",  led_a[0], 1);
        open_a = 4'b0000;
        repeat (22) tick();
        check("rst_rearm_finished", busy_a[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
